// File: rtl/res_slice_if.sv
// Operand/result bundle for res_slice_ctrl: the master drives the pass controls and
// operand slices, the slave returns residue slices, end-of-pass results and status.
interface res_slice_if #(
    parameter int DIGIT_W = 4,
    parameter int ADDR_W  = 3
);
    // Handshake: a slice moves on every rising clk edge where in_valid && in_ready;
    // in_ready is a registered status flag and never depends on in_valid.
    logic               start;
    logic               clear;
    logic               shift_en;
    logic               in_valid;
    logic               in_ready;
    logic [DIGIT_W-1:0] x_plus;
    logic [DIGIT_W-1:0] x_minus;
    logic [DIGIT_W-1:0] y_plus;
    logic [DIGIT_W-1:0] y_minus;
    logic [DIGIT_W-1:0] z_plus;
    logic [DIGIT_W-1:0] z_minus;
    logic               slice_valid;
    logic [ADDR_W-1:0]  slice_idx;
    logic [1:0]         cout_plus;
    logic [1:0]         cout_minus;
    logic [1:0]         shift_out;
    logic               borrow_out;
    logic               busy;
    logic               done;
    logic               state_dbg;

    modport master (
        output start, clear, shift_en, in_valid,
        output x_plus, x_minus, y_plus, y_minus,
        input  in_ready, z_plus, z_minus, slice_valid, slice_idx,
        input  cout_plus, cout_minus, shift_out, borrow_out, busy, done, state_dbg
    );

    modport slave (
        input  start, clear, shift_en, in_valid,
        input  x_plus, x_minus, y_plus, y_minus,
        output in_ready, z_plus, z_minus, slice_valid, slice_idx,
        output cout_plus, cout_minus, shift_out, borrow_out, busy, done, state_dbg
    );
endinterface

// File: rtl/res_slice_ctrl.sv
// Slice-serial signed-digit residue accumulator: res[i] += x + y per slice, LSB first.
// Optional borrow chain over the written slices is built only when RES_BORROW_EN is defined.
module res_slice_ctrl #(
    parameter int DIGIT_W = 4,
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 3
) (
    input  logic         clk,
    input  logic         asyn_reset,
    res_slice_if.slave   bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  idx;
    logic [1:0]         cin_p, cin_m;
    logic               sin_p, sin_m;
    logic               clr_l, shf_l;
    logic [DIGIT_W-1:0] res_p [DEPTH];
    logic [DIGIT_W-1:0] res_m [DEPTH];

    logic [DIGIT_W-1:0] z_p_q, z_m_q;
    logic               slice_valid_q, done_q;
    logic [ADDR_W-1:0]  slice_idx_q;
    logic [1:0]         cout_p_q, cout_m_q, shift_out_q;

    logic               accept, last;
    logic [DIGIT_W-1:0] base_p, base_m, wr_p, wr_m;
    logic [DIGIT_W+1:0] sum_p, sum_m;

    always_comb begin
        accept = (state == RUN) && bus.in_valid;
        last   = (idx == ADDR_W'(DEPTH - 1));
        base_p = clr_l ? '0 : res_p[idx];
        base_m = clr_l ? '0 : res_m[idx];
        sum_p  = {2'b00, base_p} + {2'b00, bus.x_plus} + {2'b00, bus.y_plus}
               + {{DIGIT_W{1'b0}}, cin_p};
        sum_m  = {2'b00, base_m} + {2'b00, bus.x_minus} + {2'b00, bus.y_minus}
               + {{DIGIT_W{1'b0}}, cin_m};
        // Shift mode drops each slice MSB into the LSB of the next slice up.
        wr_p   = shf_l ? {sum_p[DIGIT_W-2:0], sin_p} : sum_p[DIGIT_W-1:0];
        wr_m   = shf_l ? {sum_m[DIGIT_W-2:0], sin_m} : sum_m[DIGIT_W-1:0];
    end

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            state         <= IDLE;
            idx           <= '0;
            cin_p         <= '0;
            cin_m         <= '0;
            sin_p         <= 1'b0;
            sin_m         <= 1'b0;
            clr_l         <= 1'b0;
            shf_l         <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                res_p[i] <= '0;
                res_m[i] <= '0;
            end
            z_p_q         <= '0;
            z_m_q         <= '0;
            slice_valid_q <= 1'b0;
            slice_idx_q   <= '0;
            cout_p_q      <= '0;
            cout_m_q      <= '0;
            shift_out_q   <= '0;
            done_q        <= 1'b0;
        end else begin
            slice_valid_q <= 1'b0;
            done_q        <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= RUN;
                        idx   <= '0;
                        cin_p <= '0;
                        cin_m <= '0;
                        sin_p <= 1'b0;
                        sin_m <= 1'b0;
                        clr_l <= bus.clear;
                        shf_l <= bus.shift_en;
                    end
                end
                RUN: begin
                    if (accept) begin
                        res_p[idx]    <= wr_p;
                        res_m[idx]    <= wr_m;
                        z_p_q         <= wr_p;
                        z_m_q         <= wr_m;
                        slice_valid_q <= 1'b1;
                        slice_idx_q   <= idx;
                        cin_p         <= sum_p[DIGIT_W+1:DIGIT_W];
                        cin_m         <= sum_m[DIGIT_W+1:DIGIT_W];
                        sin_p         <= sum_p[DIGIT_W-1];
                        sin_m         <= sum_m[DIGIT_W-1];
                        idx           <= idx + ADDR_W'(1);
                        if (last) begin
                            state       <= IDLE;
                            done_q      <= 1'b1;
                            cout_p_q    <= sum_p[DIGIT_W+1:DIGIT_W];
                            cout_m_q    <= sum_m[DIGIT_W+1:DIGIT_W];
                            shift_out_q <= shf_l ? {sum_p[DIGIT_W-1], sum_m[DIGIT_W-1]} : 2'b00;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RES_BORROW_EN
    logic b_q, b_next, borrow_q;

    // Compare in DIGIT_W+1 bits so wp - b wraps high instead of going negative.
    always_comb begin
        b_next = ({1'b0, wr_p} - {{DIGIT_W{1'b0}}, b_q}) < {1'b0, wr_m};
    end

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            b_q      <= 1'b0;
            borrow_q <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.start) b_q <= 1'b0;
        end else if (accept) begin
            b_q <= b_next;
            if (last) borrow_q <= b_next;
        end
    end

    assign bus.borrow_out = borrow_q;
`else
    assign bus.borrow_out = 1'b0;
`endif

    assign bus.in_ready    = (state == RUN);
    assign bus.busy        = (state == RUN);
    assign bus.state_dbg   = state;
    assign bus.z_plus      = z_p_q;
    assign bus.z_minus     = z_m_q;
    assign bus.slice_valid = slice_valid_q;
    assign bus.slice_idx   = slice_idx_q;
    assign bus.cout_plus   = cout_p_q;
    assign bus.cout_minus  = cout_m_q;
    assign bus.shift_out   = shift_out_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_res_slice_ctrl.sv
// Directed, table-driven bench for res_slice_ctrl at DIGIT_W=4, DEPTH=2, with
// hand-written sequences for reset, backpressure and mid-pass abort.
module tb_res_slice_ctrl;
    localparam int DW = 4;
    localparam int DP = 2;
    localparam int AW = 1;

    logic clk;
    logic clk_en;
    logic asyn_reset;

    res_slice_if #(.DIGIT_W(DW), .ADDR_W(AW)) bus ();

    res_slice_ctrl #(.DIGIT_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .bus        (bus)
    );

    // Clock / reset: clock only toggles while clk_en is set
    initial clk = 1'b0;
    always #5 clk = clk_en ? ~clk : clk;

    // One pass over both slices; packed pairs are {slice1, slice0}
    typedef struct {
        logic              clear;
        logic              shift_en;
        logic [1:0][DW-1:0] xp, yp, xm, ym;
        logic [1:0][DW-1:0] zp, zm;
        logic [1:0]        cp, cm, sh;
        logic              b;
    } vec_t;

    vec_t tbl [8];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_borrow(input logic b);
`ifdef RES_BORROW_EN
        return b;
`else
        return 1'b0 & b;
`endif
    endfunction

    task automatic drive_idle();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.x_plus   = '0;
        bus.x_minus  = '0;
        bus.y_plus   = '0;
        bus.y_minus  = '0;
    endtask

    // Driver: runs one pass, optional gap (with a start pulse) between slices
    task automatic do_pass(input vec_t v, input int gap, input string tag);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.clear    = v.clear;
        bus.shift_en = v.shift_en;
        @(negedge clk);
        bus.start = 1'b0;
        bus.clear = 1'b0;
        bus.shift_en = 1'b0;
        chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, " busy"}, 32'(bus.busy), 32'd1);
        for (int s = 0; s < DP; s++) begin
            if (s > 0) @(negedge clk);
            bus.start    = 1'b0;
            bus.in_valid = 1'b1;
            bus.x_plus   = v.xp[s];
            bus.y_plus   = v.yp[s];
            bus.x_minus  = v.xm[s];
            bus.y_minus  = v.ym[s];
            @(posedge clk); #1;
            chk({tag, " slice_valid"}, 32'(bus.slice_valid), 32'd1);
            chk({tag, " slice_idx"}, 32'(bus.slice_idx), 32'(s));
            chk({tag, " z_plus"}, 32'(bus.z_plus), 32'(v.zp[s]));
            chk({tag, " z_minus"}, 32'(bus.z_minus), 32'(v.zm[s]));
            chk({tag, " done"}, 32'(bus.done), (s == DP - 1) ? 32'd1 : 32'd0);
            if (s == 0) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    drive_idle();
                    bus.start = (g == 0);
                    @(posedge clk); #1;
                    chk({tag, " gap slice_valid"}, 32'(bus.slice_valid), 32'd0);
                    chk({tag, " gap busy"}, 32'(bus.busy), 32'd1);
                end
            end
        end
        chk({tag, " cout_plus"}, 32'(bus.cout_plus), 32'(v.cp));
        chk({tag, " cout_minus"}, 32'(bus.cout_minus), 32'(v.cm));
        chk({tag, " shift_out"}, 32'(bus.shift_out), 32'(v.sh));
        chk({tag, " borrow_out"}, 32'(bus.borrow_out), 32'(exp_borrow(v.b)));
        @(negedge clk);
        drive_idle();
        @(posedge clk); #1;
        chk({tag, " done pulse ends"}, 32'(bus.done), 32'd0);
        chk({tag, " idle slice_valid"}, 32'(bus.slice_valid), 32'd0);
        chk({tag, " idle busy"}, 32'(bus.busy), 32'd0);
        chk({tag, " cout_plus hold"}, 32'(bus.cout_plus), 32'(v.cp));
        chk({tag, " shift_out hold"}, 32'(bus.shift_out), 32'(v.sh));
    endtask

    initial begin
        //                 clr  shf  xp            yp            xm            ym            zp            zm            cp     cm     sh     b
        tbl[0] = '{1'b1, 1'b0, {4'h1, 4'hF}, {4'h0, 4'hF}, {4'h0, 4'h0}, {4'h0, 4'h0}, {4'h2, 4'hE}, {4'h0, 4'h0}, 2'd0, 2'd0, 2'b00, 1'b0};
        tbl[1] = '{1'b1, 1'b1, {4'h8, 4'h9}, {4'h0, 4'h0}, {4'h0, 4'h0}, {4'h0, 4'h0}, {4'h1, 4'h2}, {4'h0, 4'h0}, 2'd0, 2'd0, 2'b10, 1'b0};
        tbl[2] = '{1'b1, 1'b0, {4'h3, 4'h3}, {4'h0, 4'h0}, {4'h0, 4'h0}, {4'h0, 4'h0}, {4'h3, 4'h3}, {4'h0, 4'h0}, 2'd0, 2'd0, 2'b00, 1'b0};
        tbl[3] = '{1'b0, 1'b0, {4'h3, 4'h3}, {4'h0, 4'h0}, {4'h0, 4'h0}, {4'h0, 4'h0}, {4'h6, 4'h6}, {4'h0, 4'h0}, 2'd0, 2'd0, 2'b00, 1'b0};
        tbl[4] = '{1'b1, 1'b0, {4'h0, 4'h0}, {4'h0, 4'h0}, {4'h1, 4'h0}, {4'h0, 4'h0}, {4'h0, 4'h0}, {4'h1, 4'h0}, 2'd0, 2'd0, 2'b00, 1'b1};
        tbl[5] = '{1'b1, 1'b0, {4'h0, 4'h0}, {4'h0, 4'h0}, {4'hF, 4'hF}, {4'hF, 4'hF}, {4'h0, 4'h0}, {4'hF, 4'hE}, 2'd0, 2'd1, 2'b00, 1'b0};
        tbl[6] = '{1'b0, 1'b0, {4'h0, 4'h0}, {4'h0, 4'h0}, {4'hF, 4'hF}, {4'hF, 4'hF}, {4'h0, 4'h0}, {4'hF, 4'hC}, 2'd0, 2'd2, 2'b00, 1'b0};
        tbl[7] = '{1'b1, 1'b1, {4'h0, 4'h5}, {4'h0, 4'h3}, {4'hA, 4'hC}, {4'h0, 4'h0}, {4'h1, 4'h0}, {4'h5, 4'h8}, 2'd0, 2'd0, 2'b01, 1'b1};

        clk_en     = 1'b0;
        asyn_reset = 1'b0;
        bus.clear    = 1'b0;
        bus.shift_en = 1'b0;
        drive_idle();

        // Reset with the clock stopped
        #5 asyn_reset = 1'b1;
        #1;
        chk("rst in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst slice_valid", 32'(bus.slice_valid), 32'd0);
        chk("rst z", {24'd0, bus.z_plus, bus.z_minus}, 32'd0);
        chk("rst slice_idx", 32'(bus.slice_idx), 32'd0);
        chk("rst couts", {28'd0, bus.cout_plus, bus.cout_minus}, 32'd0);
        chk("rst shift_out", 32'(bus.shift_out), 32'd0);
        chk("rst borrow_out", 32'(bus.borrow_out), 32'd0);
        #4 asyn_reset = 1'b0;
        clk_en = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) do_pass(tbl[i], 0, $sformatf("vec%0d", i));

        // Backpressure: 3 idle cycles between slices, start pulsed while busy
        do_pass(tbl[0], 3, "bp");

        // Mid-pass abort: residue now E,2; slice0 writes E+5 -> 3 before reset
        @(negedge clk);
        bus.start = 1'b1;
        bus.clear = 1'b0;
        bus.shift_en = 1'b0;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.x_plus   = 4'h5;
        @(posedge clk); #1;
        chk("abort slice0 z_plus", 32'(bus.z_plus), 32'h3);
        @(negedge clk);
        drive_idle();
        #2 asyn_reset = 1'b1;
        #1;
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort slice_valid", 32'(bus.slice_valid), 32'd0);
        chk("abort cout_plus", 32'(bus.cout_plus), 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk("abort no done", 32'(bus.done), 32'd0);
        end
        @(negedge clk);
        asyn_reset = 1'b0;
        @(posedge clk); #1;
        chk("post-abort done", 32'(bus.done), 32'd0);
        chk("post-abort in_ready", 32'(bus.in_ready), 32'd0);

        // Residue cleared by reset: clear=0 pass sees zero base
        begin
            vec_t v;
            v = '{1'b0, 1'b0, {4'h1, 4'h1}, {4'h0, 4'h0}, {4'h0, 4'h0}, {4'h0, 4'h0},
                  {4'h1, 4'h1}, {4'h0, 4'h0}, 2'd0, 2'd0, 2'b00, 1'b0};
            do_pass(v, 0, "post-reset");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
